gray_counter_n: RTL and testbench
=================================

# gray_counter_n

Parametrised Gray-code counter: a WIDTH-bit registered Gray output stepping up or down one code per enabled clock, with synchronous load, wrap or saturate at the ends, and a terminal-count flag. It replaces the fixed 3-bit event-clocked Gray counter. It is clocked from the system clock with a qualifying enable and can be instanced wherever a single-bit-change counter is needed, such as FIFO pointers, position encoders or sequencers.

## Interface
Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16).
- WRAP, 1, end-of-range behaviour: 1 wraps modulo 2^WIDTH, 0 saturates at the end value.

Ports (clock and reset are one clock, asynchronous active-low reset):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; advances the counter one step when high.
- up  in  1  direction; 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value, in binary.
- gray  out  WIDTH  registered Gray-code count.
- tc  out  1  terminal count, combinational.
- bin  out  WIDTH  registered binary count; present only with GRAY_BIN_OUT_EN.

## Operation
State and reset:
- The internal state is a binary register `b` plus a Gray register `g`.
- `g` always equals `b ^ (b >> 1)` and is updated in the same edge as `b`.
- `gray` is driven directly from `g`, with no combinational decode on the output path.
- While rst_n is low: `b` = 0, `g` = 0, bin = 0. tc evaluates combinationally and equals `en & ~up` (the count is 0).

Per rising clk edge, in priority order:
1. load = 1: `b` ← load_val. en and up are ignored.
2. en = 1, up = 1:
   - If `b` < 2^WIDTH−1: `b` ← `b`+1.
   - If `b` = 2^WIDTH−1: `b` ← 0 when WRAP=1; `b` holds when WRAP=0.
3. en = 1, up = 0:
   - If `b` > 0: `b` ← `b`−1.
   - If `b` = 0: `b` ← 2^WIDTH−1 when WRAP=1; `b` holds when WRAP=0.
4. Otherwise: `b` and `g` hold.

Terminal count:
- tc = en & ~load & ((up & `b`==2^WIDTH−1) | (~up & `b`==0)).
- tc asserts in the cycle before the wrap (or the blocked step). It is the generalisation of the old "at S7 with input high" output.
- In saturate mode, tc stays high for every cycle the counter sits at the end with en held and the direction pointing outward.

Arithmetic and invariants:
- All arithmetic is WIDTH bits, unsigned, with no carry out.
- Consecutive `gray` values differ in exactly one bit, except across a load or reset.
- A direction change takes effect on the same edge. For example, up then down returns to the previous code with no skipped state.

## Timing
- Latency: `gray` and bin reflect a step or load one clk edge after the qualifying inputs are sampled high.
- tc is valid in the same cycle as its inputs. It depends only on registered state, en, up and load, so there is no path from load_val to tc.
- Reset assertion clears outputs immediately, without waiting for clk.
- Reset release is synchronised externally. The first count occurs on the first rising edge with rst_n high and en high.
- Reset asserted mid-count discards any in-flight step. After release, counting restarts from 0.
- Simultaneous load and en: load wins, and the count resumes from load_val on the following edge.

## Configuration
- Macro: GRAY_BIN_OUT_EN.
- Defined: the bin output port exists and is driven from `b`. It is registered, has the same latency as `gray`, and resets to 0.
- Not defined: the bin port is absent. `b` remains internal, and behaviour of `gray` and tc is identical.

## Test plan
- WIDTH=3, WRAP=1, up=1, en=1 for 9 cycles after reset:
  - gray = 000,001,011,010,110,111,101,100,000.
  - tc is high only in the cycle where gray = 100.
- WIDTH=3, WRAP=1, up=0, en=1 from reset:
  - gray = 000→100→101→111.
  - tc is high in the first cycle (gray = 000).
- WIDTH=3, WRAP=0, up=1 for 10 cycles:
  - gray saturates at 100 and holds.
  - tc stays high while at 100.
  - Then up=0 gives 101 next.
- WIDTH=4, load=1 with load_val=4'd9 and en=1 in the same cycle:
  - Next gray = 1101.
  - tc is low in the load cycle.
  - A following up-step gives 1111 (binary 10).
- Mid-count reset, WIDTH=4: count to gray 0110, pulse rst_n low between clk edges.
  - gray = 0000 immediately, before the next edge.
  - First enabled edge after release gives 0001.
- Random en/up/load over 10k cycles, WIDTH=5:
  - Scoreboard checks gray == bin^(bin>>1) (with GRAY_BIN_OUT_EN).
  - Single-bit change on every non-load step.

Source files
------------

// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised WIDTH-bit Gray-code counter.
//
// The counter counts up or down one code per enabled clock, accepts a
// synchronous binary load, and either wraps or saturates at the ends of the
// range (WRAP). It holds a binary count b and a Gray register g side by side.
// g is written on the same edge as b, so the gray output comes straight from
// a flop with no decode logic on the output path. tc is combinational and
// flags the cycle in which the next step would wrap or be blocked.
//
// Optional feature macro: GRAY_BIN_OUT_EN
//   defined     -> a registered binary output port 'bin' is added, driven from b.
//   not defined -> no 'bin' port. The gray and tc behaviour is unchanged.

module gray_counter_n #(
    parameter int WIDTH = 3,     // counter width, legal range 2..16
    parameter bit WRAP  = 1'b1   // 1: wrap modulo 2^WIDTH, 0: saturate at the ends
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic             tc
`ifdef GRAY_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b;       // binary count
    logic [WIDTH-1:0] g;       // Gray image of b, registered alongside it
    logic [WIDTH-1:0] b_nxt;   // binary count for the next edge
    logic             at_max;
    logic             at_min;

    assign at_max = (b == MAX_VAL);
    assign at_min = (b == ZERO_VAL);

    // Next binary count. Priority is load, then enabled up, then enabled down, then hold.
    always_comb begin
        // NOTE: give b_nxt its default (hold) value first. Every path through the
        // block then assigns it, so no latch is inferred. Combinational blocks use
        // blocking '=' so that later statements see the earlier assignments.
        b_nxt = b;
        if (load) begin
            b_nxt = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    b_nxt = b + ONE_VAL;
                end else if (WRAP) begin
                    b_nxt = ZERO_VAL;
                end
            end else begin
                if (!at_min) begin
                    b_nxt = b - ONE_VAL;
                end else if (WRAP) begin
                    b_nxt = MAX_VAL;
                end
            end
        end
    end

    // Binary and Gray registers update together, so g always equals b ^ (b >> 1).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking '<='. Every register then samples its
        // pre-edge value, whatever order the statements are written in.
        if (!rst_n) begin
            b <= ZERO_VAL;
            g <= ZERO_VAL;
        end else begin
            b <= b_nxt;
            g <= b_nxt ^ (b_nxt >> 1);
        end
    end

    // Terminal count: the next enabled step in the current direction would
    // leave the range. load_val is deliberately kept out of this path.
    assign tc = en & ~load & ((up & at_max) | (~up & at_min));

    assign gray = g;

`ifdef GRAY_BIN_OUT_EN
    assign bin = b;
`endif

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: self-checking bench for gray_counter_n.
// Four instances share one stimulus: W3 wrap, W3 saturate, W4 wrap and W5 wrap.
// Each instance has an integer reference count. A per-cycle compare process
// checks gray and tc (and bin when GRAY_BIN_OUT_EN is defined) against it.
// Directed sections pin literal Gray sequences. A randomized section then
// exercises the W5 counter.

module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [4:0] lv;

    logic [2:0] g3w, g3s;
    logic [3:0] g4;
    logic [4:0] g5;
    logic       tc3w, tc3s, tc4, tc5;
`ifdef GRAY_BIN_OUT_EN
    logic [2:0] bn3w, bn3s;
    logic [3:0] bn4;
    logic [4:0] bn5;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Reference counts as plain integers
    int m3w, m3s, m4, m5;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3), .WRAP(1'b1)) u3w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv[2:0]), .gray(g3w), .tc(tc3w)
`ifdef GRAY_BIN_OUT_EN
        , .bin(bn3w)
`endif
    );

    gray_counter_n #(.WIDTH(3), .WRAP(1'b0)) u3s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv[2:0]), .gray(g3s), .tc(tc3s)
`ifdef GRAY_BIN_OUT_EN
        , .bin(bn3s)
`endif
    );

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv[3:0]), .gray(g4), .tc(tc4)
`ifdef GRAY_BIN_OUT_EN
        , .bin(bn4)
`endif
    );

    gray_counter_n #(.WIDTH(5), .WRAP(1'b1)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv), .gray(g5), .tc(tc5)
`ifdef GRAY_BIN_OUT_EN
        , .bin(bn5)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next count from the stated rules: load wins, wrap is modular, saturation holds.
    function automatic int next_count(int v, int w, bit wrap, bit e, bit u, bit l, int ld);
        int span;
        span = 1 << w;
        if (l)  return ld % span;
        if (!e) return v;
        if (u) begin
            if (v == span - 1 && !wrap) return v;
            return (v + 1) % span;
        end
        if (v == 0 && !wrap) return v;
        return (v + span - 1) % span;
    endfunction

    function automatic int to_gray(int v);
        return v ^ (v >> 1);
    endfunction

    function automatic bit tc_of(int v, int w, bit e, bit u, bit l);
        return e && !l && ((u && v == (1 << w) - 1) || (!u && v == 0));
    endfunction

    // Reference model: same edge and async reset as the counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m3w <= 0; m3s <= 0; m4 <= 0; m5 <= 0;
        end else begin
            m3w <= next_count(m3w, 3, 1'b1, en, up, load, int'(lv));
            m3s <= next_count(m3s, 3, 1'b0, en, up, load, int'(lv));
            m4  <= next_count(m4,  4, 1'b1, en, up, load, int'(lv));
            m5  <= next_count(m5,  5, 1'b1, en, up, load, int'(lv));
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("w3w_gray", 32'(g3w), 32'(to_gray(m3w)));
            check("w3s_gray", 32'(g3s), 32'(to_gray(m3s)));
            check("w4_gray",  32'(g4),  32'(to_gray(m4)));
            check("w5_gray",  32'(g5),  32'(to_gray(m5)));
            check("w3w_tc", 32'(tc3w), 32'(tc_of(m3w, 3, en, up, load)));
            check("w3s_tc", 32'(tc3s), 32'(tc_of(m3s, 3, en, up, load)));
            check("w4_tc",  32'(tc4),  32'(tc_of(m4,  4, en, up, load)));
            check("w5_tc",  32'(tc5),  32'(tc_of(m5,  5, en, up, load)));
`ifdef GRAY_BIN_OUT_EN
            check("w3w_bin", 32'(bn3w), 32'(m3w));
            check("w3s_bin", 32'(bn3s), 32'(m3s));
            check("w4_bin",  32'(bn4),  32'(m4));
            check("w5_bin",  32'(bn5),  32'(m5));
            check("w5_gray_vs_bin", 32'(g5), 32'(bn5 ^ (bn5 >> 1)));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] seq_up   [9]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                      3'b111, 3'b101, 3'b100, 3'b000};
        logic [2:0] seq_dn   [4]  = '{3'b000, 3'b100, 3'b101, 3'b111};
        logic [2:0] seq_sat  [10] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                      3'b111, 3'b101, 3'b100, 3'b100, 3'b100};
        logic [4:0] prev_g;
        int         prev_m;
        bit         prev_load;
        bit         have_prev;

        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; lv = '0;
        #3;
        started = 1'b1;

        // W3 wrap, counting up from reset
        en = 1'b1; up = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sample();
            check("up_seq_gray", 32'(g3w), 32'(seq_up[i]));
            check("up_seq_tc", 32'(tc3w), 32'(i == 7));
            if (i == 4) check("model_pin_up", 32'(to_gray(m3w)), 32'(seq_up[i]));
            tick();
        end

        // W3 wrap, counting down from reset. tc is en & ~up while held in reset.
        rst_n = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        check("reset_gray", 32'(g3w), 32'd0);
        check("reset_tc_down", 32'(tc3w), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("dn_seq_gray", 32'(g3w), 32'(seq_dn[i]));
            check("dn_seq_tc", 32'(tc3w), 32'(i == 0));
            if (i == 2) check("model_pin_dn", 32'(to_gray(m3w)), 32'(seq_dn[i]));
            tick();
        end

        // W3 saturate: climbs to 100 and holds, then one step down
        rst_n = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("sat_seq_gray", 32'(g3s), 32'(seq_sat[i]));
            check("sat_seq_tc", 32'(tc3s), 32'(i >= 7));
            tick();
        end
        check("model_pin_sat", 32'(to_gray(m3s)), 32'(3'b100));
        up = 1'b0;
        tick();
        sample();
        check("sat_then_down", 32'(g3s), 32'(3'b101));

        // W4: load 9 together with en. Load wins, then one up-step follows.
        tick();
        en = 1'b1; up = 1'b1; load = 1'b1; lv = 5'd9;
        sample();
        check("load_cycle_tc", 32'(tc4), 32'd0);
        tick();
        load = 1'b0;
        sample();
        check("load_gray", 32'(g4), 32'(4'b1101));
        check("model_pin_load", 32'(to_gray(m4)), 32'(4'b1101));
        tick();
        sample();
        check("load_then_up", 32'(g4), 32'(4'b1111));

        // W4: reset pulsed between edges while counting
        tick();
        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        sample();
        check("pre_reset_gray", 32'(g4), 32'(4'b0110));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_w4", 32'(g4), 32'd0);
        check("async_reset_w5", 32'(g5), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        sample();
        check("after_reset_step", 32'(g4), 32'(4'b0001));

        // Random en/up/load on all instances. The W5 single-bit-change check
        // skips any step that crosses a load.
        tick();
        have_prev = 1'b0;
        prev_g = '0; prev_m = 0; prev_load = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 15) == 0);
            lv   = 5'($urandom);
            sample();
            if (have_prev && !prev_load)
                check("w5_single_bit", 32'($countones(g5 ^ prev_g)), 32'(m5 != prev_m));
            prev_g    = g5;
            prev_m    = m5;
            prev_load = load;
            have_prev = 1'b1;
            tick();
        end

        started = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
